// File: rtl/param_rf.sv
`default_nettype none
// ============================================================================
// Module   : param_rf
// Purpose  : Parametrised register file: NUM_REGS read/write data registers,
//            a read-only ID word and one hardware event counter, on a 64-bit
//            software access bus with an access_complete handshake.
// Ports    : clk, res             - clock and asynchronous active-high reset
//            address, read_en,
//            write_en, write_data - software access request (word address)
//            read_data,
//            access_complete,
//            invalid_address      - software access response
//            hw_next, hw_wen      - hardware load of the data registers
//            hw_q, sw_written     - register contents / software-write pulses
//            cnt_inc, cnt_value,
//            cnt_overflow         - event counter
// Config   : `define PARAM_RF_RD_CLR_EN makes a software read of the counter
//            clear the counter and its overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module param_rf #(
    parameter int          NUM_REGS   = 4,
    parameter int          REG_WIDTH  = 16,
    parameter int          ADDR_WIDTH = 3,
    parameter logic [63:0] ID_VALUE   = 64'h000000000012ABCD,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            res,
    input  logic [ADDR_WIDTH+2:3]           address,
    input  logic                            read_en,
    input  logic                            write_en,
    input  logic [63:0]                     write_data,
    output logic [63:0]                     read_data,
    output logic                            access_complete,
    output logic                            invalid_address,
    input  logic [NUM_REGS*REG_WIDTH-1:0]   hw_next,
    input  logic [NUM_REGS-1:0]             hw_wen,
    output logic [NUM_REGS*REG_WIDTH-1:0]   hw_q,
    output logic [NUM_REGS-1:0]             sw_written,
    input  logic                            cnt_inc,
    output logic [CNT_WIDTH-1:0]            cnt_value,
    output logic                            cnt_overflow
);

    localparam logic [ADDR_WIDTH-1:0] c_CNT_ADDR = ADDR_WIDTH'(NUM_REGS + 1);

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_access;
    logic                  w_rd;        // read that updates read_data
    logic                  w_invalid;
    logic                  w_cnt_wr;
    logic                  w_cnt_rd;
    logic [NUM_REGS-1:0]   w_sw_hit;
    logic [63:0]           w_rd_val;
    logic                  w_unused;

    assign w_word    = address;
    assign w_access  = read_en | write_en;
    // A simultaneous read and write performs only the write.
    assign w_rd      = read_en & ~write_en;
    assign w_invalid = (w_word > c_CNT_ADDR);
    assign w_cnt_wr  = write_en & (w_word == c_CNT_ADDR);
    assign w_cnt_rd  = w_rd & (w_word == c_CNT_ADDR);
    assign w_unused  = ^write_data;

    // ------------------------------------------------------------------------
    // Data registers: a software write beats a same-cycle hardware load.
    // ------------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < NUM_REGS; k++) begin : g_reg
            logic [REG_WIDTH-1:0] r_val;

            assign w_sw_hit[k] = write_en & (w_word == ADDR_WIDTH'(k + 1));

            always_ff @(posedge clk or posedge res) begin
                if (res) begin
                    r_val <= '0;
                end else if (w_sw_hit[k]) begin
                    r_val <= write_data[REG_WIDTH-1:0];
                end else if (hw_wen[k]) begin
                    r_val <= hw_next[k*REG_WIDTH +: REG_WIDTH];
                end
            end

            assign hw_q[k*REG_WIDTH +: REG_WIDTH] = r_val;
        end
    endgenerate

    logic [NUM_REGS-1:0] r_sw_written;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_sw_written <= '0;
        end else begin
            r_sw_written <= w_sw_hit;
        end
    end

    assign sw_written = r_sw_written;

    // ------------------------------------------------------------------------
    // Event counter
    // ------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_ovf;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_cnt_wr) begin
            // Software write wins; a coincident increment is dropped.
            r_cnt <= write_data[CNT_WIDTH-1:0];
            r_ovf <= 1'b0;
        end
`ifdef PARAM_RF_RD_CLR_EN
        else if (w_cnt_rd) begin
            // Read-to-clear: an increment in the read cycle is not lost.
            r_cnt <= cnt_inc ? CNT_WIDTH'(1) : '0;
            r_ovf <= 1'b0;
        end
`endif
        else if (cnt_inc) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (&r_cnt) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign cnt_value    = r_cnt;
    assign cnt_overflow = r_ovf;

    // ------------------------------------------------------------------------
    // Read mux; unmapped words read as zero.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_val = '0;
        if (w_word == '0) begin
            w_rd_val = ID_VALUE;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_word == ADDR_WIDTH'(i + 1)) begin
                w_rd_val = 64'(hw_q[i*REG_WIDTH +: REG_WIDTH]);
            end
        end
        if (w_word == c_CNT_ADDR) begin
            w_rd_val = 64'(r_cnt);
            if (CNT_WIDTH < 64) begin
                w_rd_val[63] = r_ovf;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response pipeline. State changes and the read snapshot happen on the
    // sampling edge; the response is presented one edge later. Reset clears
    // the pending stage, so an in-flight access never completes.
    // ------------------------------------------------------------------------
    logic        r_pend;
    logic        r_pend_rd;
    logic        r_pend_inv;
    logic [63:0] r_pend_data;
    logic [63:0] r_rdata;
    logic        r_ack;
    logic        r_inv;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_pend      <= 1'b0;
            r_pend_rd   <= 1'b0;
            r_pend_inv  <= 1'b0;
            r_pend_data <= '0;
            r_rdata     <= '0;
            r_ack       <= 1'b0;
            r_inv       <= 1'b0;
        end else begin
            r_pend      <= w_access;
            r_pend_rd   <= w_rd;
            r_pend_inv  <= w_access & w_invalid;
            r_pend_data <= w_rd_val;
            r_ack       <= r_pend;
            r_inv       <= r_pend & r_pend_inv;
            if (r_pend && r_pend_rd) begin
                r_rdata <= r_pend_data;
            end
        end
    end

    assign read_data       = r_rdata;
    assign access_complete = r_ack;
    assign invalid_address = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_param_rf.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_rf
// Purpose  : Directed self-checking bench for param_rf (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_rf;

    localparam logic [63:0] c_ID = 64'h000000000012ABCD;

    logic        clk;
    logic        res;
    logic [5:3]  address;
    logic        read_en;
    logic        write_en;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        access_complete;
    logic        invalid_address;
    logic [63:0] hw_next;
    logic [3:0]  hw_wen;
    logic [63:0] hw_q;
    logic [3:0]  sw_written;
    logic        cnt_inc;
    logic [31:0] cnt_value;
    logic        cnt_overflow;

    int checks;
    int errors;

    param_rf dut (
        .clk             (clk),
        .res             (res),
        .address         (address),
        .read_en         (read_en),
        .write_en        (write_en),
        .write_data      (write_data),
        .read_data       (read_data),
        .access_complete (access_complete),
        .invalid_address (invalid_address),
        .hw_next         (hw_next),
        .hw_wen          (hw_wen),
        .hw_q            (hw_q),
        .sw_written      (sw_written),
        .cnt_inc         (cnt_inc),
        .cnt_value       (cnt_value),
        .cnt_overflow    (cnt_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one strobe for a single edge; returns just after the sampling edge.
    task automatic do_acc(input logic [2:0] w, input logic rd, input logic wr,
                          input logic [63:0] d);
        address    = w;
        read_en    = rd;
        write_en   = wr;
        write_data = d;
        tick();
        read_en    = 1'b0;
        write_en   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] w, input logic [63:0] exp_d,
                      input logic exp_inv);
        do_acc(w, 1'b1, 1'b0, 64'h0);
        chk({tag, "_lat"}, 64'(access_complete), 64'h0);
        tick();
        chk({tag, "_ack"}, 64'(access_complete), 64'h1);
        chk({tag, "_inv"}, 64'(invalid_address), 64'(exp_inv));
        chk({tag, "_data"}, read_data, exp_d);
        tick();
        chk({tag, "_ack_end"}, 64'(access_complete), 64'h0);
    endtask

    task automatic wr(input string tag, input logic [2:0] w, input logic [63:0] d,
                      input logic [3:0] exp_sw, input logic exp_inv);
        do_acc(w, 1'b0, 1'b1, d);
        chk({tag, "_sw"}, 64'(sw_written), 64'(exp_sw));
        chk({tag, "_lat"}, 64'(access_complete), 64'h0);
        tick();
        chk({tag, "_ack"}, 64'(access_complete), 64'h1);
        chk({tag, "_inv"}, 64'(invalid_address), 64'(exp_inv));
        chk({tag, "_sw_end"}, 64'(sw_written), 64'h0);
        tick();
        chk({tag, "_ack_end"}, 64'(access_complete), 64'h0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        res        = 1'b1;
        address    = '0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        write_data = '0;
        hw_next    = '0;
        hw_wen     = '0;
        cnt_inc    = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_rdata", read_data, 64'h0);
        chk("rst_ack", 64'(access_complete), 64'h0);
        chk("rst_inv", 64'(invalid_address), 64'h0);
        chk("rst_hwq", hw_q, 64'h0);
        chk("rst_cnt", 64'(cnt_value), 64'h0);
        chk("rst_ovf", 64'(cnt_overflow), 64'h0);
        chk("rst_sw", 64'(sw_written), 64'h0);
        res = 1'b0;
        tick();

        // ID word
        rd("id", 3'd0, c_ID, 1'b0);

        // Software writes to all data registers, then read back
        for (int k = 1; k <= 4; k++) begin
            wr("wr_data", 3'(k), 64'h555AAA555AAA555A, 4'(1 << (k - 1)), 1'b0);
        end
        chk("hwq_555a", hw_q, {4{16'h555A}});
        for (int k = 1; k <= 4; k++) begin
            rd("rd_data", 3'(k), 64'h000000000000555A, 1'b0);
        end

        // Software write beats a coincident hardware load on register 2
        hw_next    = {16'h0000, 16'h1234, 16'h0000, 16'h0000};
        hw_wen     = 4'b0100;
        address    = 3'd3;
        write_en   = 1'b1;
        write_data = 64'h000000000000BEEF;
        tick();
        write_en   = 1'b0;
        chk("hw_sw_win", hw_q, {16'h555A, 16'hBEEF, 16'h555A, 16'h555A});
        chk("hw_sw_pulse", 64'(sw_written), 64'h4);
        tick();
        chk("hw_load", hw_q, {16'h555A, 16'h1234, 16'h555A, 16'h555A});
        chk("hw_sw_ack", 64'(access_complete), 64'h1);
        chk("hw_only_sw", 64'(sw_written), 64'h0);
        // Independent loads on registers 0 and 3
        hw_next = {16'hC0DE, 16'h1111, 16'h2222, 16'hF00D};
        hw_wen  = 4'b1001;
        tick();
        hw_wen  = 4'b0000;
        chk("hw_indep", hw_q, {16'hC0DE, 16'h1234, 16'h555A, 16'hF00D});
        tick();

        // Read, then a combined read+write: only the write happens
        rd("rd_reg0", 3'd1, 64'h000000000000F00D, 1'b0);
        do_acc(3'd1, 1'b1, 1'b1, 64'h0000000000000077);
        chk("rw_sw", 64'(sw_written), 64'h1);
        chk("rw_hwq", hw_q, {16'hC0DE, 16'h1234, 16'h555A, 16'h0077});
        tick();
        chk("rw_ack", 64'(access_complete), 64'h1);
        chk("rw_rdata_hold", read_data, 64'h000000000000F00D);
        tick();
        chk("rw_ack_end", 64'(access_complete), 64'h0);

        // Unmapped words
        rd("inv_rd6", 3'd6, 64'h0, 1'b1);
        rd("inv_rd7", 3'd7, 64'h0, 1'b1);
        wr("inv_wr6", 3'd6, 64'hFFFFFFFFFFFFFFFF, 4'b0000, 1'b1);
        wr("inv_wr7", 3'd7, 64'hFFFFFFFFFFFFFFFF, 4'b0000, 1'b1);
        chk("inv_hwq", hw_q, {16'hC0DE, 16'h1234, 16'h555A, 16'h0077});
        chk("inv_cnt", 64'(cnt_value), 64'h0);
        chk("inv_ovf", 64'(cnt_overflow), 64'h0);

        // Write to ID is ignored but acknowledged as valid
        wr("id_wr", 3'd0, 64'hFFFFFFFFFFFFFFFF, 4'b0000, 1'b0);
        rd("id_after_wr", 3'd0, c_ID, 1'b0);

        // Counter wrap and overflow
        wr("cnt_wr", 3'd5, 64'h00000000FFFFFFFE, 4'b0000, 1'b0);
        chk("cnt_loaded", 64'(cnt_value), 64'hFFFFFFFE);
        cnt_inc = 1'b1;
        tick();
        chk("cnt_inc1", 64'(cnt_value), 64'hFFFFFFFF);
        chk("cnt_ovf1", 64'(cnt_overflow), 64'h0);
        tick();
        chk("cnt_wrap", 64'(cnt_value), 64'h0);
        chk("cnt_ovf_set", 64'(cnt_overflow), 64'h1);
        tick();
        cnt_inc = 1'b0;
        chk("cnt_inc3", 64'(cnt_value), 64'h1);
        chk("cnt_ovf_sticky", 64'(cnt_overflow), 64'h1);
        rd("cnt_rd", 3'd5, 64'h8000000000000001, 1'b0);
`ifdef PARAM_RF_RD_CLR_EN
        chk("cnt_rdclr_val", 64'(cnt_value), 64'h0);
        chk("cnt_rdclr_ovf", 64'(cnt_overflow), 64'h0);
`else
        chk("cnt_rd_val", 64'(cnt_value), 64'h1);
        chk("cnt_rd_ovf", 64'(cnt_overflow), 64'h1);
`endif

        // Counter read coinciding with an increment
        wr("cnt_wr5", 3'd5, 64'h0000000000000005, 4'b0000, 1'b0);
        chk("cnt_wr_clr_ovf", 64'(cnt_overflow), 64'h0);
        address = 3'd5;
        read_en = 1'b1;
        cnt_inc = 1'b1;
        tick();
        read_en = 1'b0;
        cnt_inc = 1'b0;
`ifdef PARAM_RF_RD_CLR_EN
        chk("cnt_rd_inc", 64'(cnt_value), 64'h1);
`else
        chk("cnt_rd_inc", 64'(cnt_value), 64'h6);
`endif
        tick();
        chk("cnt_rd_inc_ack", 64'(access_complete), 64'h1);
        chk("cnt_rd_inc_data", read_data, 64'h0000000000000005);
        tick();

        // Reset in the middle of an access aborts it
        do_acc(3'd0, 1'b1, 1'b0, 64'h0);
        #2 res = 1'b1;
        #1;
        chk("mid_rst_hwq", hw_q, 64'h0);
        chk("mid_rst_cnt", 64'(cnt_value), 64'h0);
        chk("mid_rst_rdata", read_data, 64'h0);
        @(posedge clk);
        #1;
        res = 1'b0;
        chk("mid_rst_ack", 64'(access_complete), 64'h0);
        tick();
        chk("mid_rst_ack2", 64'(access_complete), 64'h0);
        chk("mid_rst_inv", 64'(invalid_address), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
